// File: rtl/codec_init_pkg.sv
// Shared types and the default register table for the CODEC init sequencer.
// Swap default_entry() (or the table it reads) to retarget a different board.
package codec_init_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_ID_RD    = 4'd1;
  localparam state_t S_ID_WAIT  = 4'd2;
  localparam state_t S_WR       = 4'd3;
  localparam state_t S_WR_WAIT  = 4'd4;
  localparam state_t S_VFY_RD   = 4'd5;
  localparam state_t S_VFY_WAIT = 4'd6;
  localparam state_t S_NEXT     = 4'd7;
  localparam state_t S_DONE     = 4'd8;
  localparam state_t S_ERROR    = 4'd9;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ID      = 2'd1,
    ERR_VERIFY  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] data;
    logic       vfy;
  } entry_t;

  localparam int DEFAULT_LEN = 9;

  // Reset first, activation last; self-clearing registers are not read back.
  localparam entry_t DEFAULT_TABLE [DEFAULT_LEN] = '{
    '{8'h0F, 9'h000, 1'b0},
    '{8'h06, 9'h010, 1'b1},
    '{8'h00, 9'h097, 1'b1},
    '{8'h01, 9'h097, 1'b1},
    '{8'h04, 9'h012, 1'b1},
    '{8'h05, 9'h000, 1'b1},
    '{8'h07, 9'h00A, 1'b1},
    '{8'h08, 9'h000, 1'b1},
    '{8'h09, 9'h001, 1'b0}
  };

  // Tables longer than the default are padded with repeats of the activate write.
  function automatic entry_t default_entry(input int unsigned i);
    if (i < DEFAULT_LEN) return DEFAULT_TABLE[i[3:0]];
    return DEFAULT_TABLE[DEFAULT_LEN-1];
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Combinational init-table lookup; out-of-range indices return an all-zero entry.
module codec_init_rom
  import codec_init_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [IDX_W-1:0] idx,
  output entry_t           entry
);

  always_comb begin
    entry = '0;
    if (32'(idx) < NUM_REGS) entry = default_entry(32'(idx));
  end

endmodule

// File: rtl/codec_init_seq.sv
// CODEC init sequencer: identity check, then table-driven writes with optional
// readback, per-transaction timeout and bounded retry, sticky done/error status.
module codec_init_seq
  import codec_init_pkg::*;
#(
  parameter int         NUM_REGS       = 8,
  parameter int         VERIFY_EN      = 1,
  parameter int         MAX_RETRIES    = 3,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] ID_ADDR        = 8'h00,
  parameter logic [8:0] ID_VALUE       = 9'h097,
  parameter int         IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reinit,
  output logic             codec_rd_en,
  output logic             codec_wr_en,
  output logic [7:0]       codec_reg_addr,
  output logic [8:0]       codec_data_out,
  input  logic [8:0]       codec_data_in,
  input  logic             codec_data_in_valid,
  input  logic             codec_wr_done,
  output logic             busy,
  output logic             init_done,
  output logic             init_error,
  output logic [1:0]       error_code,
  output logic [IDX_W-1:0] error_index
);

  localparam int                TCNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        RETRY_LIMIT = 3'(MAX_RETRIES);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_REGS - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        retry;
  logic [TCNT_W-1:0] tcnt;
  entry_t            entry;

  logic pulse_cycle;
  logic rd_ok;
  logic wr_ok;
  logic expired;
  logic retries_left;
  logic vfy_this;

  codec_init_rom #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rom (
    .idx   (idx),
    .entry (entry)
  );

  // Strobes coincident with our own request pulse cannot be real completions.
  assign pulse_cycle  = codec_rd_en | codec_wr_en;
  assign rd_ok        = codec_data_in_valid & ~pulse_cycle;
  assign wr_ok        = codec_wr_done & ~pulse_cycle;
  assign expired      = (tcnt == TCNT_LAST);
  assign retries_left = (retry != RETRY_LIMIT);
  assign vfy_this     = (VERIFY_EN != 0) && entry.vfy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      retry          <= '0;
      tcnt           <= '0;
      codec_rd_en    <= 1'b0;
      codec_wr_en    <= 1'b0;
      codec_reg_addr <= '0;
      codec_data_out <= '0;
      busy           <= 1'b0;
      init_done      <= 1'b0;
      init_error     <= 1'b0;
      error_code     <= ERR_NONE;
      error_index    <= '0;
    end else begin
      codec_rd_en <= 1'b0;
      codec_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          busy  <= 1'b1;
          retry <= '0;
          idx   <= '0;
          state <= S_ID_RD;
        end

        S_ID_RD: begin
          codec_rd_en    <= 1'b1;
          codec_reg_addr <= ID_ADDR;
          tcnt           <= '0;
          state          <= S_ID_WAIT;
        end

        S_ID_WAIT: begin
          if (rd_ok && codec_data_in == ID_VALUE) begin
            retry <= '0;
            idx   <= '0;
            state <= S_WR;
          end else if (rd_ok || expired) begin
            if (retries_left) begin
              retry <= retry + 3'd1;
              state <= S_ID_RD;
            end else begin
              busy        <= 1'b0;
              init_error  <= 1'b1;
              error_code  <= rd_ok ? ERR_ID : ERR_TIMEOUT;
              error_index <= '0;
              state       <= S_ERROR;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WR: begin
          codec_wr_en    <= 1'b1;
          codec_reg_addr <= entry.addr;
          codec_data_out <= entry.data;
          tcnt           <= '0;
          state          <= S_WR_WAIT;
        end

        // Write and its readback form one transaction: the retry budget
        // spans both and is only refreshed once the entry completes.
        S_WR_WAIT: begin
          if (wr_ok) begin
            state <= vfy_this ? S_VFY_RD : S_NEXT;
          end else if (expired) begin
            if (retries_left) begin
              retry <= retry + 3'd1;
              state <= S_WR;
            end else begin
              busy        <= 1'b0;
              init_error  <= 1'b1;
              error_code  <= ERR_TIMEOUT;
              error_index <= idx;
              state       <= S_ERROR;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_VFY_RD: begin
          codec_rd_en    <= 1'b1;
          codec_reg_addr <= entry.addr;
          tcnt           <= '0;
          state          <= S_VFY_WAIT;
        end

        // A bad readback rewrites the entry; a lost readback only re-reads it.
        S_VFY_WAIT: begin
          if (rd_ok && codec_data_in == entry.data) begin
            state <= S_NEXT;
          end else if (rd_ok || expired) begin
            if (retries_left) begin
              retry <= retry + 3'd1;
              state <= rd_ok ? S_WR : S_VFY_RD;
            end else begin
              busy        <= 1'b0;
              init_error  <= 1'b1;
              error_code  <= rd_ok ? ERR_VERIFY : ERR_TIMEOUT;
              error_index <= idx;
              state       <= S_ERROR;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_NEXT: begin
          retry <= '0;
          if (idx == IDX_LAST) begin
            busy      <= 1'b0;
            init_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_WR;
          end
        end

        S_DONE, S_ERROR: begin
          if (reinit) begin
            busy        <= 1'b1;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
            error_code  <= ERR_NONE;
            error_index <= '0;
            retry       <= '0;
            idx         <= '0;
            state       <= S_ID_RD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench: two sequencers (verify on / off) share one latency-5 echo slave
// model with knobs for a bad ID, a single corrupt readback and a lost write strobe.
module tb_codec_init_seq;

  localparam int LAT     = 5;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       reinit [2];
  logic       rd_en  [2];
  logic       wr_en  [2];
  logic [7:0] addr   [2];
  logic [8:0] dout   [2];
  logic [8:0] din    [2];
  logic       dvalid [2];
  logic       wdone  [2];
  logic       busy   [2];
  logic       done   [2];
  logic       err    [2];
  logic [1:0] ecode  [2];
  logic [2:0] eidx   [2];

  codec_init_seq #(.VERIFY_EN(1)) dut (
    .clk(clk), .reset(reset), .reinit(reinit[0]),
    .codec_rd_en(rd_en[0]), .codec_wr_en(wr_en[0]),
    .codec_reg_addr(addr[0]), .codec_data_out(dout[0]),
    .codec_data_in(din[0]), .codec_data_in_valid(dvalid[0]),
    .codec_wr_done(wdone[0]), .busy(busy[0]), .init_done(done[0]),
    .init_error(err[0]), .error_code(ecode[0]), .error_index(eidx[0])
  );

  codec_init_seq #(.VERIFY_EN(0)) dut_nv (
    .clk(clk), .reset(reset), .reinit(reinit[1]),
    .codec_rd_en(rd_en[1]), .codec_wr_en(wr_en[1]),
    .codec_reg_addr(addr[1]), .codec_data_out(dout[1]),
    .codec_data_in(din[1]), .codec_data_in_valid(dvalid[1]),
    .codec_wr_done(wdone[1]), .busy(busy[1]), .init_done(done[1]),
    .init_error(err[1]), .error_code(ecode[1]), .error_index(eidx[1])
  );

  // Slave knobs, written only by the stimulus process
  logic [8:0] id_val;
  int         corrupt_wr_no;
  logic       drop_en;
  logic [7:0] drop_addr;

  // Slave state and transaction logs
  int         cyc = 0;
  int         n_rd [2] = '{0, 0};
  int         n_wr [2] = '{0, 0};
  bit         rd_pend [2];
  bit         wr_pend [2];
  int         cnt [2];
  logic [8:0] resp [2];
  logic       last_wr [2] = '{1'b0, 1'b0};
  logic [7:0] last_wr_addr [2];
  logic [8:0] mem [2][256];
  logic [7:0] wr_addr_log [128];
  logic [8:0] wr_data_log [128];
  int         wr_time [128];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      dvalid[k] <= 1'b0;
      wdone[k]  <= 1'b0;
      if (reset) begin
        rd_pend[k] <= 1'b0;
        wr_pend[k] <= 1'b0;
      end else if (rd_en[k]) begin
        n_rd[k]    <= n_rd[k] + 1;
        rd_pend[k] <= 1'b1;
        cnt[k]     <= LAT;
        if (last_wr[k] && addr[k] == last_wr_addr[k])
          resp[k] <= (k == 0 && n_wr[0] == corrupt_wr_no) ? (mem[k][addr[k]] ^ 9'h001)
                                                          : mem[k][addr[k]];
        else
          resp[k] <= id_val;
        last_wr[k] <= 1'b0;
      end else if (wr_en[k]) begin
        if (k == 0 && n_wr[0] < 128) begin
          wr_addr_log[n_wr[0]] <= addr[0];
          wr_data_log[n_wr[0]] <= dout[0];
          wr_time[n_wr[0]]     <= cyc;
        end
        n_wr[k]            <= n_wr[k] + 1;
        mem[k][addr[k]]    <= dout[k];
        last_wr[k]         <= 1'b1;
        last_wr_addr[k]    <= addr[k];
        if (!(k == 0 && drop_en && addr[k] == drop_addr)) begin
          wr_pend[k] <= 1'b1;
          cnt[k]     <= LAT;
        end
      end else if (rd_pend[k] || wr_pend[k]) begin
        if (cnt[k] == 1) begin
          if (rd_pend[k]) begin
            dvalid[k] <= 1'b1;
            din[k]    <= resp[k];
          end else begin
            wdone[k] <= 1'b1;
          end
          rd_pend[k] <= 1'b0;
          wr_pend[k] <= 1'b0;
        end else begin
          cnt[k] <= cnt[k] - 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_end(input int k, input int limit, input string tag);
    int i = 0;
    while (!(done[k] || err[k]) && i < limit) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(done[k] | err[k]), 1);
  endtask

  task automatic pulse_reinit(input int k);
    @(negedge clk);
    reinit[k] = 1'b1;
    @(negedge clk);
    reinit[k] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},   32'(rd_en[0]), 0);
    check({tag, "_wr"},   32'(wr_en[0]), 0);
    check({tag, "_addr"}, 32'(addr[0]),  0);
    check({tag, "_data"}, 32'(dout[0]),  0);
    check({tag, "_busy"}, 32'(busy[0]),  0);
    check({tag, "_done"}, 32'(done[0]),  0);
    check({tag, "_err"},  32'(err[0]),   0);
    check({tag, "_code"}, 32'(ecode[0]), 0);
    check({tag, "_idx"},  32'(eidx[0]),  0);
  endtask

  // Default table truncated to 8 entries
  logic [7:0] exp_addr [8] = '{8'h0F, 8'h06, 8'h00, 8'h01, 8'h04, 8'h05, 8'h07, 8'h08};
  logic [8:0] exp_data [8] = '{9'h000, 9'h010, 9'h097, 9'h097, 9'h012, 9'h000, 9'h00A, 9'h000};

  initial begin
    int bw, br, i;
    reset         = 1'b1;
    reinit[0]     = 1'b0;
    reinit[1]     = 1'b0;
    id_val        = 9'h097;
    corrupt_wr_no = -1;
    drop_en       = 1'b0;
    drop_addr     = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy[0]), 1);
    check("start_rd_low", 32'(rd_en[0]), 0);
    @(negedge clk);
    check("id_rd_pulse", 32'(rd_en[0]), 1);
    check("id_rd_addr", 32'(addr[0]), 8'h00);

    // Ideal slave, both instances
    wait_end(0, 2000, "ok_end");
    check("ok_done", 32'(done[0]), 1);
    check("ok_code", 32'(ecode[0]), 0);
    check("ok_busy", 32'(busy[0]), 0);
    check("ok_nwr", n_wr[0], 8);
    check("ok_nrd", n_rd[0], 8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("ok_wa%0d", j), 32'(wr_addr_log[j]), 32'(exp_addr[j]));
      check($sformatf("ok_wd%0d", j), 32'(wr_data_log[j]), 32'(exp_data[j]));
    end
    wait_end(1, 2000, "nv_end");
    check("nv_done", 32'(done[1]), 1);
    check("nv_nwr", n_wr[1], 8);
    check("nv_nrd", n_rd[1], 1);

    // reinit after DONE repeats the whole sequence
    bw = n_wr[0];
    pulse_reinit(0);
    check("ri_done_clr", 32'(done[0]), 0);
    check("ri_busy", 32'(busy[0]), 1);
    wait_end(0, 2000, "ri_end");
    check("ri_done", 32'(done[0]), 1);
    check("ri_nwr", n_wr[0] - bw, 8);

    // Single corrupt readback of entry 2
    bw = n_wr[0];
    br = n_rd[0];
    corrupt_wr_no = bw + 3;
    pulse_reinit(0);
    wait_end(0, 2000, "cr_end");
    check("cr_done", 32'(done[0]), 1);
    check("cr_err", 32'(err[0]), 0);
    check("cr_nwr", n_wr[0] - bw, 9);
    check("cr_nrd", n_rd[0] - br, 9);
    check("cr_wa2", 32'(wr_addr_log[bw + 2]), 8'h00);
    check("cr_wa3", 32'(wr_addr_log[bw + 3]), 8'h00);
    check("cr_wa4", 32'(wr_addr_log[bw + 4]), 8'h01);
    corrupt_wr_no = -1;

    // Identity mismatch on every attempt
    bw = n_wr[0];
    br = n_rd[0];
    id_val = 9'h000;
    pulse_reinit(0);
    wait_end(0, 2000, "id_end");
    check("id_err", 32'(err[0]), 1);
    check("id_done", 32'(done[0]), 0);
    check("id_code", 32'(ecode[0]), 1);
    check("id_idx", 32'(eidx[0]), 0);
    check("id_nrd", n_rd[0] - br, 4);
    check("id_nwr", n_wr[0] - bw, 0);
    check("id_busy", 32'(busy[0]), 0);

    // Entry 3 never completes its write
    bw = n_wr[0];
    br = n_rd[0];
    id_val    = 9'h097;
    drop_en   = 1'b1;
    drop_addr = 8'h01;
    pulse_reinit(0);
    check("to_err_clr", 32'(err[0]), 0);
    check("to_code_clr", 32'(ecode[0]), 0);
    wait_end(0, 5 * TIMEOUT + 500, "to_end");
    check("to_err", 32'(err[0]), 1);
    check("to_code", 32'(ecode[0]), 3);
    check("to_idx", 32'(eidx[0]), 3);
    check("to_nwr", n_wr[0] - bw, 7);
    check("to_nrd", n_rd[0] - br, 3);
    check("to_gap", wr_time[bw + 6] - wr_time[bw + 5], TIMEOUT + 1);
    drop_en = 1'b0;

    // Reset while entry 4 waits for its write strobe
    bw = n_wr[0];
    pulse_reinit(0);
    i = 0;
    while (n_wr[0] < bw + 5 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("mr_reach_e4", 32'(n_wr[0] - bw), 5);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mr");
    reset = 1'b0;
    bw = n_wr[0];
    br = n_rd[0];
    @(negedge clk);
    check("mr_busy", 32'(busy[0]), 1);
    wait_end(0, 2000, "mr_end");
    check("mr_done", 32'(done[0]), 1);
    check("mr_nwr", n_wr[0] - bw, 8);
    check("mr_nrd", n_rd[0] - br, 8);
    check("mr_wa0", 32'(wr_addr_log[bw]), 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
